// File: rtl/uart_rx_cfg_if.sv
// Consumer-side bundle of uart_rx_cfg: received word, error flags, busy status
// and the ready/valid handshake of the holding register.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_Rx_Valid;
  logic                 i_Rx_Ready;
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Overrun;
  logic                 o_Busy;

  modport master (
    output o_Rx_Valid,
    output o_Rx_Data,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Overrun,
    output o_Busy,
    input  i_Rx_Ready
  );

  modport slave (
    input  o_Rx_Valid,
    input  o_Rx_Data,
    input  o_Parity_Err,
    input  o_Frame_Err,
    input  o_Overrun,
    input  o_Busy,
    output i_Rx_Ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width, parity and stop bits, with
// parity/framing/overrun detection and a ready/valid holding register.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Rx_Serial,
  uart_rx_cfg_if.master io_Rx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_t;

  state_t               r_State;
  state_t               w_NextState;
  logic                 r_Sync1;
  logic                 r_Sync2;
  logic                 w_Rxs;
  logic [CW-1:0]        r_Count;
  logic [IW-1:0]        r_BitIdx;
  logic                 r_StopIdx;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_ParErr;
  logic                 r_FrmErr;
  logic                 w_Tick;
  logic                 w_FrameDone;
  logic                 w_ParOnes;
  logic                 w_Busy;

  logic                 r_Valid;
  logic [DATA_BITS-1:0] r_Data;
  logic                 r_ParFlag;
  logic                 r_FrmFlag;
  logic                 r_Overrun;

  assign w_Rxs = r_Sync2;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  always_comb begin
    w_NextState = r_State;
    unique case (r_State)
      S_IDLE:    if (!w_Rxs) w_NextState = S_START;
      S_START:   if (w_Tick) w_NextState = w_Rxs ? S_IDLE : S_DATA;
      S_DATA:    if (w_Tick && (r_BitIdx == IDX_LAST))
                   w_NextState = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:  if (w_Tick) w_NextState = S_STOP;
      S_STOP:    if (w_FrameDone) w_NextState = w_Rxs ? S_IDLE : S_BRKWAIT;
      S_BRKWAIT: if (w_Rxs) w_NextState = S_IDLE;
      default:   w_NextState = S_IDLE;
    endcase
  end

  // The start bit is sampled mid-bit; every later sample is one full bit period on.
  always_comb begin
    w_Busy      = (r_State != S_IDLE);
    w_Tick      = 1'b0;
    w_FrameDone = 1'b0;
    w_ParOnes   = (^r_Shift) ^ w_Rxs;
    case (r_State)
      S_START:                  w_Tick = (r_Count == CNT_HALF);
      S_DATA, S_PARITY, S_STOP: w_Tick = (r_Count == CNT_LAST);
      default:                  w_Tick = 1'b0;
    endcase
    w_FrameDone = (r_State == S_STOP) && w_Tick && (r_StopIdx == STOP_LAST);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Sync1   <= 1'b1;
      r_Sync2   <= 1'b1;
      r_Count   <= '0;
      r_BitIdx  <= '0;
      r_StopIdx <= 1'b0;
      r_Shift   <= '0;
      r_ParErr  <= 1'b0;
      r_FrmErr  <= 1'b0;
    end else begin
      r_Sync1 <= i_Rx_Serial;
      r_Sync2 <= r_Sync1;
      if ((r_State == S_IDLE) || (r_State == S_BRKWAIT) || w_Tick) begin
        r_Count <= '0;
      end else begin
        r_Count <= r_Count + 1'b1;
      end
      case (r_State)
        S_IDLE: begin
          r_BitIdx  <= '0;
          r_StopIdx <= 1'b0;
          r_ParErr  <= 1'b0;
          r_FrmErr  <= 1'b0;
        end
        S_DATA: begin
          if (w_Tick) begin
            r_Shift <= {w_Rxs, r_Shift[DATA_BITS-1:1]};
            if (r_BitIdx != IDX_LAST) begin
              r_BitIdx <= r_BitIdx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          // Odd mode wants an odd count of ones over data plus parity bit.
          if (w_Tick) begin
            r_ParErr <= (PARITY == 1) ? ~w_ParOnes : w_ParOnes;
          end
        end
        S_STOP: begin
          if (w_Tick) begin
            if (!w_Rxs) begin
              r_FrmErr <= 1'b1;
            end
            if (!w_FrameDone) begin
              r_StopIdx <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A finished frame may replace the held word only if it is empty or leaving this cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Valid   <= 1'b0;
      r_Data    <= '0;
      r_ParFlag <= 1'b0;
      r_FrmFlag <= 1'b0;
      r_Overrun <= 1'b0;
    end else if (w_FrameDone) begin
      if (!r_Valid || io_Rx.i_Rx_Ready) begin
        r_Valid   <= 1'b1;
        r_Data    <= r_Shift;
        r_ParFlag <= r_ParErr;
        r_FrmFlag <= r_FrmErr | ~w_Rxs;
        r_Overrun <= 1'b0;
      end else begin
        r_Overrun <= 1'b1;
      end
    end else if (r_Valid && io_Rx.i_Rx_Ready) begin
      r_Valid   <= 1'b0;
      r_ParFlag <= 1'b0;
      r_FrmFlag <= 1'b0;
      r_Overrun <= 1'b0;
    end
  end

  assign io_Rx.o_Rx_Valid   = r_Valid;
  assign io_Rx.o_Rx_Data    = r_Data;
  assign io_Rx.o_Parity_Err = r_ParFlag;
  assign io_Rx.o_Frame_Err  = r_FrmFlag;
  assign io_Rx.o_Overrun    = r_Overrun;
  assign io_Rx.o_Busy       = w_Busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances with
// hand-built frames and hand-computed expected words and flags.
module tb_uart_rx_cfg;

  logic clock;
  logic reset;
  logic rxA, rxB, rxC;
  logic readyA, readyB, readyC;

  int vectorCount = 0;
  int missCount   = 0;

  int         gotA = 0;
  logic [7:0] lastDataA;
  int         gotC = 0;
  logic [7:0] lastDataC;
  logic       lastParC, lastFrmC, lastOvrC;
  int         base;

  uart_rx_cfg_if #(.DATA_BITS(8)) busA();
  uart_rx_cfg_if #(.DATA_BITS(7)) busB();
  uart_rx_cfg_if #(.DATA_BITS(8)) busC();

  assign busA.i_Rx_Ready = readyA;
  assign busB.i_Rx_Ready = readyB;
  assign busC.i_Rx_Ready = readyC;

  uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rxA), .io_Rx(busA));

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dutB (
    .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rxB), .io_Rx(busB));

  uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dutC (
    .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rxC), .io_Rx(busC));

  always #5 clock = ~clock;

  // Record every word the consumer actually takes on the A and C instances.
  always @(negedge clock) begin
    if (busA.o_Rx_Valid && readyA) begin
      gotA++;
      lastDataA = busA.o_Rx_Data;
    end
    if (busC.o_Rx_Valid && readyC) begin
      gotC++;
      lastDataC = busC.o_Rx_Data;
      lastParC  = busC.o_Parity_Err;
      lastFrmC  = busC.o_Frame_Err;
      lastOvrC  = busC.o_Overrun;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] frame8N1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame8N2(input logic [7:0] d, input logic s2);
    return {5'b0, s2, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame7E1(input logic [6:0] d, input logic p);
    return {6'b0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic driveLine(input int inst, input logic v);
    case (inst)
      0:       rxA = v;
      1:       rxB = v;
      default: rxC = v;
    endcase
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Frame cycle k counts from the cycle the start bit is driven; pulseAt raises readyA for that one cycle.
  task automatic applyStimulus(input int inst, input int cpb, input logic [15:0] bits,
                               input int nbits, input int pulseAt);
    int k;
    k = 0;
    for (int b = 0; b < nbits; b++) begin
      driveLine(inst, bits[b]);
      for (int c = 0; c < cpb; c++) begin
        if (k == pulseAt) readyA = 1'b1;
        @(posedge clock);
        #1;
        if (k == pulseAt) readyA = 1'b0;
        k++;
      end
    end
  endtask

  task automatic pulseReady(input int inst);
    case (inst)
      0:       readyA = 1'b1;
      1:       readyB = 1'b1;
      default: readyC = 1'b1;
    endcase
    @(posedge clock);
    #1;
    case (inst)
      0:       readyA = 1'b0;
      1:       readyB = 1'b0;
      default: readyC = 1'b0;
    endcase
  endtask

  initial begin
    clock  = 1'b0;
    reset  = 1'b1;
    rxA    = 1'b1;
    rxB    = 1'b1;
    rxC    = 1'b1;
    readyA = 1'b0;
    readyB = 1'b0;
    readyC = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_valid", busA.o_Rx_Valid, 0);
    checkOutput("rst_data", busA.o_Rx_Data, 0);
    checkOutput("rst_perr", busA.o_Parity_Err, 0);
    checkOutput("rst_ferr", busA.o_Frame_Err, 0);
    checkOutput("rst_ovr", busA.o_Overrun, 0);
    checkOutput("rst_busy", busA.o_Busy, 0);
    checkOutput("rst_validB", busB.o_Rx_Valid, 0);
    reset = 1'b0;
    idleCycles(4);

    // 8N1 word with the consumer always ready: one handshake, clean flags.
    readyA = 1'b1;
    base = gotA;
    applyStimulus(0, 8, frame8N1(8'hA5), 10, -1);
    idleCycles(4);
    checkOutput("a5_count", gotA - base, 1);
    checkOutput("a5_data", lastDataA, 8'hA5);
    checkOutput("a5_valid_after", busA.o_Rx_Valid, 0);
    checkOutput("a5_ovr", busA.o_Overrun, 0);
    checkOutput("a5_ferr", busA.o_Frame_Err, 0);

    // Stalled consumer: second word dropped, first kept, overrun raised.
    readyA = 1'b0;
    applyStimulus(0, 8, frame8N1(8'h11), 10, -1);
    applyStimulus(0, 8, frame8N1(8'h22), 10, -1);
    idleCycles(4);
    checkOutput("ovr_valid", busA.o_Rx_Valid, 1);
    checkOutput("ovr_data", busA.o_Rx_Data, 8'h11);
    checkOutput("ovr_flag", busA.o_Overrun, 1);
    checkOutput("ovr_ferr", busA.o_Frame_Err, 0);
    pulseReady(0);
    checkOutput("ovr_clr_valid", busA.o_Rx_Valid, 0);
    checkOutput("ovr_clr_flag", busA.o_Overrun, 0);
    checkOutput("ovr_clr_data", busA.o_Rx_Data, 8'h11);
    applyStimulus(0, 8, frame8N1(8'h33), 10, -1);
    idleCycles(4);
    checkOutput("x33_valid", busA.o_Rx_Valid, 1);
    checkOutput("x33_data", busA.o_Rx_Data, 8'h33);
    checkOutput("x33_ovr", busA.o_Overrun, 0);

    // Reset during data bit 4 abandons the frame and the held 0x33.
    applyStimulus(0, 8, frame8N1(8'h77), 5, -1);
    rxA = 1'b1;
    idleCycles(3);
    checkOutput("mid_busy", busA.o_Busy, 1);
    reset = 1'b1;
    idleCycles(1);
    checkOutput("mrst_valid", busA.o_Rx_Valid, 0);
    checkOutput("mrst_data", busA.o_Rx_Data, 0);
    checkOutput("mrst_busy", busA.o_Busy, 0);
    checkOutput("mrst_ovr", busA.o_Overrun, 0);
    reset = 1'b0;
    idleCycles(16);
    applyStimulus(0, 8, frame8N1(8'h5A), 10, -1);
    idleCycles(4);
    checkOutput("x5a_valid", busA.o_Rx_Valid, 1);
    checkOutput("x5a_data", busA.o_Rx_Data, 8'h5A);
    checkOutput("x5a_ferr", busA.o_Frame_Err, 0);
    checkOutput("x5a_ovr", busA.o_Overrun, 0);
    pulseReady(0);

    // Low glitch of H-1 = 2 clocks: START is entered but abandoned.
    base = gotA;
    rxA = 1'b0;
    idleCycles(2);
    rxA = 1'b1;
    idleCycles(2);
    checkOutput("glitch_busy", busA.o_Busy, 1);
    idleCycles(10);
    checkOutput("glitch_idle", busA.o_Busy, 0);
    checkOutput("glitch_valid", busA.o_Rx_Valid, 0);
    checkOutput("glitch_count", gotA - base, 0);

    // Back-to-back frames; ready pulsed in frame 2's final stop-sample cycle (78).
    base = gotA;
    applyStimulus(0, 8, frame8N1(8'hC3), 10, -1);
    applyStimulus(0, 8, frame8N1(8'h69), 10, 78);
    idleCycles(4);
    checkOutput("b2b_count", gotA - base, 1);
    checkOutput("b2b_first", lastDataA, 8'hC3);
    checkOutput("b2b_valid", busA.o_Rx_Valid, 1);
    checkOutput("b2b_data", busA.o_Rx_Data, 8'h69);
    checkOutput("b2b_ovr", busA.o_Overrun, 0);
    pulseReady(0);

    // 7E1: 0x41 has two ones, so a parity bit of 1 is wrong.
    applyStimulus(1, 16, frame7E1(7'h41, 1'b1), 10, -1);
    idleCycles(4);
    checkOutput("e41_valid", busB.o_Rx_Valid, 1);
    checkOutput("e41_data", busB.o_Rx_Data, 7'h41);
    checkOutput("e41_perr", busB.o_Parity_Err, 1);
    checkOutput("e41_ferr", busB.o_Frame_Err, 0);
    pulseReady(1);
    checkOutput("e41_clr_perr", busB.o_Parity_Err, 0);
    applyStimulus(1, 16, frame7E1(7'h07, 1'b1), 10, -1);
    idleCycles(4);
    checkOutput("e07_data", busB.o_Rx_Data, 7'h07);
    checkOutput("e07_perr", busB.o_Parity_Err, 0);

    // 8N2 with second stop bit low, then a 30-bit break, then a clean word.
    base = gotC;
    applyStimulus(2, 8, frame8N2(8'h96, 1'b0), 11, -1);
    idleCycles(30 * 8);
    checkOutput("brk_count", gotC - base, 1);
    checkOutput("brk_data", lastDataC, 8'h96);
    checkOutput("brk_ferr", lastFrmC, 1);
    checkOutput("brk_busy", busC.o_Busy, 1);
    rxC = 1'b1;
    idleCycles(16);
    checkOutput("brk_release", busC.o_Busy, 0);
    applyStimulus(2, 8, frame8N2(8'h3C, 1'b1), 11, -1);
    idleCycles(4);
    checkOutput("x3c_count", gotC - base, 2);
    checkOutput("x3c_data", lastDataC, 8'h3C);
    checkOutput("x3c_ferr", lastFrmC, 0);
    checkOutput("x3c_perr", lastParC, 0);
    checkOutput("x3c_ovr", lastOvrC, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
